// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line levels for the FIFO-fed UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_START_LVL = 1'b0;
   localparam logic UART_STOP_LVL  = 1'b1;
   localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; bit_tick on the last cycle of a bit, bit_tick_next one cycle earlier
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick,
   output logic bit_tick_next
);

   localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_WIDTH'(CLKS_PER_BIT - 2);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (clear || (cnt_q == CNT_MAX)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick      = (cnt_q == CNT_MAX) && !clear;
   assign bit_tick_next = (cnt_q == CNT_PRE) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the byte FIFO onto an 8N1 UART line, LSB first
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_q,
   output logic       fifo_rdreq,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   tx_state_t  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       tx_q, tx_d;
   logic       rdreq_q, rdreq_d;
   logic       busy_q, busy_d;
   logic       tx_done_q, tx_done_d;
   logic       bit_tick;
   logic       bit_tick_next;
   logic       baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   // Clearing during FETCH makes the first START cycle count 0.
   assign baud_clear = (state_q == FETCH);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk           (clk),
      .rst           (rst),
      .clear         (baud_clear),
      .bit_tick      (bit_tick),
      .bit_tick_next (bit_tick_next)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      unique case (state_q)
         IDLE: begin
            if (rdreq_q) state_d = FETCH;
         end
         FETCH: begin
            shift_d   = fifo_q;
            bit_idx_d = '0;
            state_d   = START;
         end
         START: begin
            if (bit_tick) state_d = DATA;
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) state_d = STOP;
         end
         STOP: begin
            if (bit_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each registered output lines up with state_q.
   // The pop is therefore decided one cycle ahead, which keeps the inter-frame gap at 2 cycles.
   always_comb begin
      rdreq_d   = (state_d == IDLE) && !rdreq_q && tx_en && !fifo_empty;
      busy_d    = (state_d != IDLE);
      tx_done_d = (state_q == STOP) && bit_tick_next;
      tx_d      = UART_IDLE_LVL;
      unique case (state_d)
         START:  tx_d = UART_START_LVL;
         DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: tx_d = parity_q;
`else
         PARITY: tx_d = UART_STOP_LVL;
`endif
         STOP:   tx_d = UART_STOP_LVL;
         default: tx_d = UART_IDLE_LVL;
      endcase
   end

`ifdef FIFO_UART_TX_PARITY_EN
   always_comb begin
      parity_d = parity_q;
      if (state_q == FETCH) parity_d = ^fifo_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= UART_IDLE_LVL;
         rdreq_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         rdreq_q   <= rdreq_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign fifo_rdreq = rdreq_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx against a frame-level line model
module tb_fifo_uart_tx;

   localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = (10 + PAR) * C;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_en = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_q = 8'h00;
   logic       fifo_rdreq;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int checks = 0;
   int failures = 0;
   int rd_underflow = 0;

   logic [7:0] mem[$];
   logic [7:0] wr_req[$];
   logic       tx_h[$];
   logic       rdreq_h[$];
   logic       busy_h[$];
   logic       done_h[$];
   int         rd_at[$];

   fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rdreq (fifo_rdreq),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Registered-output FIFO: q is valid the cycle after a pop.
   always @(posedge clk) begin
      if (fifo_rdreq === 1'b1) begin
         if (mem.size() == 0) rd_underflow++;
         else fifo_q <= mem.pop_front();
      end
      while (wr_req.size() > 0) mem.push_back(wr_req.pop_front());
      fifo_empty <= (mem.size() == 0);
   end

   always @(negedge clk) begin
      tx_h.push_back(tx);
      rdreq_h.push_back(fifo_rdreq);
      busy_h.push_back(busy);
      done_h.push_back(tx_done);
   end

   function automatic logic model_level(input logic [7:0] b, input int k);
      int slot;
      slot = k / C;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (PAR == 1 && slot == 9) return ^b;
      return 1'b1;
   endfunction

   // Mismatches of one observed frame (rdreq at index rd) against the model for byte b.
   function automatic int frame_errors(input int rd, input logic [7:0] b);
      int e;
      e = 0;
      if (rd + FL + 2 > tx_h.size()) return 999;
      if (tx_h[rd] !== 1'b1 || tx_h[rd+1] !== 1'b1) e++;
      if (busy_h[rd] !== 1'b0) e++;
      for (int k = 0; k < FL; k++) begin
         if (tx_h[rd+2+k] !== model_level(b, k)) e++;
         if (done_h[rd+2+k] !== (k == FL - 1)) e++;
      end
      for (int k = 1; k < FL + 2; k++) begin
         if (busy_h[rd+k] !== 1'b1) e++;
      end
      return e;
   endfunction

   function automatic int count_ones(input int from, input int sel);
      int n;
      n = 0;
      for (int i = from; i < tx_h.size(); i++) begin
         if (sel == 0 && done_h[i] === 1'b1) n++;
         if (sel == 1 && busy_h[i] === 1'b1) n++;
         if (sel == 2 && tx_h[i] !== 1'b1) n++;
      end
      return n;
   endfunction

   task automatic scan_rd(input int from);
      rd_at.delete();
      for (int i = from; i < rdreq_h.size(); i++) begin
         if (rdreq_h[i] === 1'b1) rd_at.push_back(i);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_req.push_back(b);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tx_en = 1'b1;
      tick(3);
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
      checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq got=%b want=0", fifo_rdreq); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", tx_done); end
      rst = 1'b0;
      tx_en = 1'b0;
      tick(2);
   endtask

   task automatic test_single;
      int mark;
      mark = tx_h.size();
      tx_en = 1'b1;
      write_byte(8'hA5);
      tick(FL + 12);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 1) begin failures++; $display("FAIL single_rdreq_count got=%0d want=1", rd_at.size()); end
      if (rd_at.size() >= 1) begin
         checks++; if (frame_errors(rd_at[0], 8'hA5) !== 0) begin failures++; $display("FAIL single_frame errors=%0d want=0", frame_errors(rd_at[0], 8'hA5)); end
      end
      checks++; if (count_ones(mark, 0) !== 1) begin failures++; $display("FAIL single_done_count got=%0d want=1", count_ones(mark, 0)); end
      checks++; if (count_ones(mark, 1) !== FL + 1) begin failures++; $display("FAIL single_busy_len got=%0d want=%0d", count_ones(mark, 1), FL + 1); end
      checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b want=1", fifo_empty); end
   endtask

   task automatic test_back_to_back;
      int mark;
      logic [7:0] exp_b[3];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
      mark = tx_h.size();
      tx_en = 1'b1;
      for (int i = 0; i < 3; i++) write_byte(exp_b[i]);
      tick(3 * (FL + 2) + 12);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 3) begin failures++; $display("FAIL b2b_rdreq_count got=%0d want=3", rd_at.size()); end
      if (rd_at.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (frame_errors(rd_at[i], exp_b[i]) !== 0) begin failures++; $display("FAIL b2b_frame%0d errors=%0d want=0", i, frame_errors(rd_at[i], exp_b[i])); end
         end
         for (int i = 0; i < 2; i++) begin
            checks++; if (rd_at[i+1] - rd_at[i] !== FL + 2) begin failures++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, rd_at[i+1] - rd_at[i], FL + 2); end
         end
      end
      checks++; if (count_ones(mark, 0) !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d want=3", count_ones(mark, 0)); end
   endtask

   task automatic test_empty_disabled;
      int mark;
      mark = tx_h.size();
      tx_en = 1'b1;
      tick(50);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 0) begin failures++; $display("FAIL empty_rdreq got=%0d want=0", rd_at.size()); end
      checks++; if (count_ones(mark, 2) !== 0) begin failures++; $display("FAIL empty_tx_low_cycles got=%0d want=0", count_ones(mark, 2)); end
      checks++; if (count_ones(mark, 1) !== 0) begin failures++; $display("FAIL empty_busy_cycles got=%0d want=0", count_ones(mark, 1)); end
      tx_en = 1'b0;
      mark = tx_h.size();
      write_byte(8'h55);
      tick(20);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 0) begin failures++; $display("FAIL disabled_rdreq got=%0d want=0", rd_at.size()); end
      mark = tx_h.size();
      tx_en = 1'b1;
      tick(FL + 10);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 1) begin failures++; $display("FAIL enable_rdreq got=%0d want=1", rd_at.size()); end
      if (rd_at.size() == 1) begin
         checks++; if (frame_errors(rd_at[0], 8'h55) !== 0) begin failures++; $display("FAIL enable_frame errors=%0d want=0", frame_errors(rd_at[0], 8'h55)); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int mark;
      int budget;
      tx_en = 1'b1;
      write_byte(8'h81);
      budget = 20;
      while (fifo_rdreq !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         checks++; failures++;
         $display("FAIL rstmid_wait_rdreq got=timeout want=rdreq");
         return;
      end
      // rdreq cycle + 2 -> tx falls; DATA bit 3 starts 4 bit periods later
      tick(2 + 4 * C + 1);
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_bit3 got tx=%b busy=%b want tx=0 busy=1", tx, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b want=1", tx); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", tx_done); end
      mark = tx_h.size();
      tick(60);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 0 || count_ones(mark, 2) !== 0 || count_ones(mark, 0) !== 0) begin
         failures++;
         $display("FAIL rstmid_idle got rdreq=%0d tx_low=%0d done=%0d want all 0", rd_at.size(), count_ones(mark, 2), count_ones(mark, 0));
      end
   endtask

   task automatic test_en_drop;
      int mark;
      int budget;
      logic [7:0] b0;
      logic [7:0] b1;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      mark = tx_h.size();
      tx_en = 1'b1;
      write_byte(b0);
      write_byte(b1);
      budget = 20;
      while (fifo_rdreq !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         checks++; failures++;
         $display("FAIL endrop_wait_rdreq got=timeout want=rdreq");
         return;
      end
      tick(3);
      tx_en = 1'b0;
      tick(FL + 20);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 1) begin failures++; $display("FAIL endrop_rdreq_count got=%0d want=1", rd_at.size()); end
      if (rd_at.size() == 1) begin
         checks++; if (frame_errors(rd_at[0], b0) !== 0) begin failures++; $display("FAIL endrop_frame0 errors=%0d want=0", frame_errors(rd_at[0], b0)); end
      end
      mark = tx_h.size();
      tx_en = 1'b1;
      tick(FL + 10);
      scan_rd(mark);
      checks++; if (rd_at.size() !== 1) begin failures++; $display("FAIL endrop_resume_count got=%0d want=1", rd_at.size()); end
      if (rd_at.size() == 1) begin
         checks++; if (frame_errors(rd_at[0], b1) !== 0) begin failures++; $display("FAIL endrop_frame1 errors=%0d want=0", frame_errors(rd_at[0], b1)); end
      end
   endtask

   task automatic test_random_batches;
      int mark;
      int n;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      mark = tx_h.size();
      tx_en = 1'b1;
      for (int batch = 0; batch < 4; batch++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
         end
         tick(n * (FL + 2) + 6 + $urandom_range(0, 7));
      end
      scan_rd(mark);
      checks++; if (rd_at.size() !== exp_q.size()) begin failures++; $display("FAIL rand_rdreq_count got=%0d want=%0d", rd_at.size(), exp_q.size()); end
      if (rd_at.size() == exp_q.size()) begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (frame_errors(rd_at[i], exp_q[i]) !== 0) begin failures++; $display("FAIL rand_frame%0d byte=%h errors=%0d want=0", i, exp_q[i], frame_errors(rd_at[i], exp_q[i])); end
         end
      end
      checks++; if (rd_underflow !== 0) begin failures++; $display("FAIL rdreq_while_empty got=%0d want=0", rd_underflow); end
   endtask

   task automatic test_frame_length;
      int mark;
      int fall;
      int done_i;
      logic [7:0] vals[2];
      vals[0] = 8'h07; vals[1] = 8'h03;
      tx_en = 1'b1;
      for (int v = 0; v < 2; v++) begin
         mark = tx_h.size();
         write_byte(vals[v]);
         tick(FL + 12);
         scan_rd(mark);
         fall = -1;
         done_i = -1;
         if (rd_at.size() == 1) fall = rd_at[0] + 2;
         for (int i = mark; i < done_h.size(); i++) if (done_h[i] === 1'b1) done_i = i;
         checks++; if (fall < 0 || done_i - fall + 1 !== FL) begin failures++; $display("FAIL frame_len byte=%h got=%0d want=%0d", vals[v], done_i - fall + 1, FL); end
`ifdef FIFO_UART_TX_PARITY_EN
         if (fall >= 0) begin
            checks++; if (tx_h[fall + 9 * C + 1] !== ^vals[v]) begin failures++; $display("FAIL parity_bit byte=%h got=%b want=%b", vals[v], tx_h[fall + 9 * C + 1], ^vals[v]); end
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_empty_disabled();
      test_reset_mid_frame();
      test_en_drop();
      test_random_batches();
      test_frame_length();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the 8-bit system FIFO; serialises each popped byte onto a UART TX line (8N1, LSB first).
- Sits between the FIFO output port (empty/q/rdreq) and the board TX pin.
- Drains the FIFO autonomously while tx_en is high.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the baud counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  8  FIFO read data; valid the cycle after a rdreq pulse.
- fifo_rdreq  output  1  one-cycle pop request to FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high from fetch through end of stop bit.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (synchronous): state=IDLE, tx=1, fifo_rdreq=0, busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
- Reset mid-frame: the next cycle shows tx=1 and busy=0. The popped byte is discarded. The FIFO is never re-read for it.
- All outputs are registered.
- FSM states: IDLE, FETCH, START, DATA, STOP (PARITY when enabled).
- IDLE:
  - If tx_en and !fifo_empty, assert fifo_rdreq for exactly this one cycle and go to FETCH.
  - Otherwise stay in IDLE with tx=1.
- FETCH: one cycle; latch fifo_q into the shift register; busy=1; go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - Bit index counts 0..7; after bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the final cycle, then return to IDLE.
- Latency: rdreq at cycle N -> tx falls at cycle N+2.
- Frame length from tx fall to IDLE is 10*CLKS_PER_BIT cycles (11 with parity).
- Back-to-back bytes: idle gap between frames is exactly 2 cycles (IDLE with rdreq, then FETCH), tx=1.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on entering START.
- fifo_rdreq is never asserted while fifo_empty=1, nor outside IDLE. At most one pop per frame.
- tx_en deassertion mid-frame does not abort the frame; it only blocks the next fetch.
- fifo_empty rising during a frame has no effect on that frame.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 frame of 10*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, FETCH, START, DATA, PARITY, STOP}; PARITY is always declared.
  - Constants UART_DATA_BITS=8, UART_START_LVL=1'b0, UART_STOP_LVL=1'b1, UART_IDLE_LVL=1'b1.
- Sub-module uart_baud_gen:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, clear. Output bit_tick, a pulse on count wrap.
  - Instantiated once inside fifo_uart_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and an instance of the team FIFO as source.
- Single byte: write 8'hA5, tx_en=1.
  - One rdreq pulse; tx falls 2 cycles later.
  - Line reads 0,1,0,1,0,0,1,0,1,1 (4 cycles each).
  - tx_done is a single pulse at the end; empty=1 afterwards.
- Back-to-back: write 8'h00, 8'hFF, 8'h3C.
  - Three frames, exactly 3 rdreq pulses.
  - 2-cycle idle gap between frames; 3 tx_done pulses.
- Empty / disabled:
  - fifo_empty=1 with tx_en=1 for 50 cycles -> rdreq=0, tx=1, busy=0.
  - Then write 8'h55 with tx_en=0 -> no rdreq.
  - Set tx_en=1 -> frame starts.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h81.
  - Next cycle: tx=1, busy=0, no tx_done.
  - After release with an empty FIFO, the line stays idle.
- tx_en drop mid-frame: deassert during the START bit with 2 bytes queued.
  - The first frame completes; the second byte is not fetched until tx_en=1.
- Parity (FIFO_UART_TX_PARITY_EN defined):
  - 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
  - Frame length 44 cycles.
